// File: rtl/csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csr_arbiter
// Brief    : Two-requester round-robin arbiter onto a single CSR port.
//            Writes take 3 cycles (arbitrate, strobe, ack); reads take 4
//            (arbitrate, strobe, capture, ack).
// Revision : 1.0 - initial release
// ============================================================================
module csr_arbiter #(
  parameter int ADD_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  // requester 0
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADD_WIDTH-1:0]  m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  // requester 1
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADD_WIDTH-1:0]  m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  // shared CSR port
  output logic [ADD_WIDTH-1:0]  csr_addr,
  output logic                  csr_wr,
  output logic [DATA_WIDTH-1:0] csr_wr_data,
  output logic                  csr_rd,
  input  logic [DATA_WIDTH-1:0] csr_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q,  last_d;   // last granted requester (1 = m1)
  logic                  win_q,   win_d;    // requester owning the transaction
  logic                  wr_q,    wr_d;
  logic [ADD_WIDTH-1:0]  addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  // Next-state, arbitration, request latching and read-data capture
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester that was not served last wins.
          win_d   = (m0_req && m1_req) ? ~last_q : m1_req;
          last_d  = win_d;
          wr_d    = win_d ? m1_wr    : m0_wr;
          addr_d  = win_d ? m1_addr  : m0_addr;
          wdata_d = win_d ? m1_wdata : m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE:  state_d = wr_q ? ACK : RDWAIT;
      RDWAIT: begin
        // Read data is valid the cycle after the strobe.
        if (win_q) rdata1_d = csr_rd_data;
        else       rdata0_d = csr_rd_data;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes and acks decode from the state register so reset clears them at once
  always_comb begin
    csr_wr      = (state_q == ISSUE) &&  wr_q;
    csr_rd      = (state_q == ISSUE) && !wr_q;
    m0_ack      = (state_q == ACK)   && !win_q;
    m1_ack      = (state_q == ACK)   &&  win_q;
    csr_addr    = addr_q;
    csr_wr_data = wdata_q;
    m0_rdata    = rdata0_q;
    m1_rdata    = rdata1_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_arbiter
// Brief    : Self-checking bench for csr_arbiter. A transaction-level model
//            schedules the expected strobe/ack cycles of each granted access
//            and every output is compared each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  csr_addr;
  logic        csr_wr, csr_rd;
  logic [31:0] csr_wr_data, csr_rd_data;

  csr_arbiter #(.ADD_WIDTH(8), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .csr_addr(csr_addr), .csr_wr(csr_wr), .csr_wr_data(csr_wr_data),
    .csr_rd(csr_rd), .csr_rd_data(csr_rd_data)
  );

  always #5 aclk = ~aclk;

  int tests  = 0;
  int failed = 0;

  // Transaction-level reference model
  int          cyc;
  int          start_c;     // cycle in which the current transaction was granted
  int          free_c;      // first cycle the arbiter can accept a new request
  bit          act_wr, act_m, last_g;
  logic [7:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mdl_rdata [2];
  bit          grants [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc          = 0;
    start_c      = -100;
    free_c       = 0;
    act_wr       = 1'b1;
    act_m        = 1'b0;
    last_g       = 1'b1;
    lat_addr     = '0;
    lat_wdata    = '0;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
  endtask

  task automatic set_m0(input logic req, input logic wr, input logic [7:0] a, input logic [31:0] d);
    m0_req = req; m0_wr = wr; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic wr, input logic [7:0] a, input logic [31:0] d);
    m1_req = req; m1_wr = wr; m1_addr = a; m1_wdata = d;
  endtask

  // Randomise everything; each req is high with probability pct percent
  task automatic rand_inputs(input int pct);
    set_m0(($urandom_range(99) < pct), 1'($urandom), 8'($urandom), $urandom);
    set_m1(($urandom_range(99) < pct), 1'($urandom), 8'($urandom), $urandom);
    csr_rd_data = $urandom;
  endtask

  // Check this cycle's outputs against the model, let the model consume this
  // cycle's inputs, then advance to the next cycle (sampled 1 after posedge).
  task automatic cycle();
    int ack_c;
    bit m;
    ack_c = start_c + (act_wr ? 2 : 3);
    chk("csr_wr",      32'(csr_wr),  32'(act_wr  && cyc == start_c + 1));
    chk("csr_rd",      32'(csr_rd),  32'(!act_wr && cyc == start_c + 1));
    chk("m0_ack",      32'(m0_ack),  32'(cyc == ack_c && !act_m));
    chk("m1_ack",      32'(m1_ack),  32'(cyc == ack_c &&  act_m));
    chk("csr_addr",    32'(csr_addr), 32'(lat_addr));
    chk("csr_wr_data", csr_wr_data,  lat_wdata);
    chk("m0_rdata",    m0_rdata,     mdl_rdata[0]);
    chk("m1_rdata",    m1_rdata,     mdl_rdata[1]);
    if (!act_wr && cyc == start_c + 2) mdl_rdata[act_m] = csr_rd_data;
    if (cyc >= free_c && (m0_req || m1_req)) begin
      m         = (m0_req && m1_req) ? !last_g : m1_req;
      last_g    = m;
      act_m     = m;
      act_wr    = m ? m1_wr    : m0_wr;
      lat_addr  = m ? m1_addr  : m0_addr;
      lat_wdata = m ? m1_wdata : m0_wdata;
      start_c   = cyc;
      free_c    = cyc + (act_wr ? 3 : 4);
      grants.push_back(m);
    end
    @(posedge aclk); #1;
    cyc++;
  endtask

  initial begin
    // ---- reset state ----
    areset = 1'b1;
    set_m0(0, 0, 8'h00, 32'h0);
    set_m1(0, 0, 8'h00, 32'h0);
    csr_rd_data = '0;
    @(posedge aclk); @(posedge aclk); #1;
    chk("rst_csr_wr",   32'(csr_wr), 32'd0);
    chk("rst_csr_rd",   32'(csr_rd), 32'd0);
    chk("rst_acks",     32'({m0_ack, m1_ack}), 32'd0);
    chk("rst_csr_addr", 32'(csr_addr), 32'd0);
    chk("rst_rdata",    m0_rdata | m1_rdata, 32'd0);
    areset = 1'b0;
    model_reset();

    // ---- m0 write 0x08 / 0xDEADBEEF ----
    set_m0(1, 1, 8'h08, 32'hDEADBEEF);
    cycle();
    set_m0(0, 0, 8'h00, 32'h0);
    chk("wr_strobe", 32'(csr_wr), 32'd1);
    chk("wr_addr",   32'(csr_addr), 32'h08);
    chk("wr_data",   csr_wr_data, 32'hDEADBEEF);
    cycle();
    chk("wr_m0_ack", 32'(m0_ack), 32'd1);
    chk("wr_m1_ack", 32'(m1_ack), 32'd0);
    cycle(); cycle();

    // ---- m1 read 0x04, CSR returns 0x12345678 ----
    csr_rd_data = 32'h12345678;
    set_m1(1, 0, 8'h04, 32'h0);
    cycle();
    set_m1(0, 0, 8'h00, 32'h0);
    chk("rd_strobe", 32'(csr_rd), 32'd1);
    chk("rd_addr",   32'(csr_addr), 32'h04);
    cycle(); cycle();
    chk("rd_m1_ack",   32'(m1_ack), 32'd1);
    chk("rd_m1_rdata", m1_rdata, 32'h12345678);
    chk("rd_m0_rdata", m0_rdata, 32'h0);
    cycle(); cycle();

    // ---- m0 write, req dropped one cycle after grant ----
    set_m0(1, 1, 8'h20, 32'hCAFE0001);
    cycle();
    m0_req = 1'b0;
    cycle();
    chk("drop_m0_ack", 32'(m0_ack), 32'd1);
    cycle(); cycle();

    // ---- both requesters reading continuously from reset release ----
    areset = 1'b1;
    set_m0(1, 0, 8'h10, 32'h0);
    set_m1(1, 0, 8'h14, 32'h0);
    #1;
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    grants.delete();
    for (int i = 0; i < 16; i++) begin
      csr_rd_data = $urandom;
      cycle();
    end
    chk("rr_count", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      chk("rr_g0", 32'(grants[0]), 32'd0);
      chk("rr_g1", 32'(grants[1]), 32'd1);
      chk("rr_g2", 32'(grants[2]), 32'd0);
      chk("rr_g3", 32'(grants[3]), 32'd1);
    end

    // ---- randomized traffic ----
    for (int i = 0; i < 400; i++) begin
      rand_inputs((i < 200) ? 40 : 90);
      cycle();
    end
    set_m0(0, 0, 8'h00, 32'h0);
    set_m1(0, 0, 8'h00, 32'h0);
    for (int i = 0; i < 5; i++) cycle();

    // ---- reset while a read sits in RDWAIT ----
    mdl_rdata[0] = m0_rdata;  // value only used to make the point: nonzero before reset
    set_m0(1, 0, 8'h30, 32'h0);
    csr_rd_data = 32'hA5A5A5A5;
    cycle();
    m0_req = 1'b0;
    cycle();
    areset = 1'b1;
    #1;
    chk("arst_csr_wr",   32'(csr_wr), 32'd0);
    chk("arst_csr_rd",   32'(csr_rd), 32'd0);
    chk("arst_m0_ack",   32'(m0_ack), 32'd0);
    chk("arst_m1_ack",   32'(m1_ack), 32'd0);
    chk("arst_m0_rdata", m0_rdata, 32'd0);
    chk("arst_m1_rdata", m1_rdata, 32'd0);
    chk("arst_csr_addr", 32'(csr_addr), 32'd0);
    @(posedge aclk); #1;
    chk("arst_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
    areset = 1'b0;
    model_reset();
    set_m1(1, 0, 8'h44, 32'h0);
    csr_rd_data = 32'h0BADF00D;
    cycle();
    m1_req = 1'b0;
    cycle(); cycle();
    chk("post_rst_m1_ack",   32'(m1_ack), 32'd1);
    chk("post_rst_m1_rdata", m1_rdata, 32'h0BADF00D);
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    failed++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/csr_arbiter.md
CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 SHALL have parameter ADD_WIDTH, default 8: CSR address width in bits, byte address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: CSR data width in bits.
REQ-003 SHALL have port aclk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port areset, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports m0_req / m1_req, input, 1: requester N access request, level.
REQ-006 SHALL have ports m0_wr / m1_wr, input, 1: 1 = write, 0 = read; valid while req is high.
REQ-007 SHALL have ports m0_addr / m1_addr, input, ADD_WIDTH: access address; valid while req is high.
REQ-008 SHALL have ports m0_wdata / m1_wdata, input, DATA_WIDTH: write data; valid while req is high.
REQ-009 SHALL have ports m0_ack / m1_ack, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdata / m1_rdata, output, DATA_WIDTH: read data, valid from the ack cycle.
REQ-011 SHALL have port csr_addr, output, ADD_WIDTH: shared CSR port address.
REQ-012 SHALL have port csr_wr, output, 1: CSR write strobe.
REQ-013 SHALL have port csr_wr_data, output, DATA_WIDTH: CSR write data.
REQ-014 SHALL have port csr_rd, output, 1: CSR read strobe.
REQ-015 SHALL have port csr_rd_data, input, DATA_WIDTH: CSR read data, valid the cycle after csr_rd.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, RDWAIT, ACK.
REQ-017 SHALL, in IDLE with any req high, select a winner, latch its wr/addr/wdata, and go to ISSUE; with no req, stay in IDLE.
REQ-018 SHALL arbitrate round-robin: with one req high, that requester wins; with both high, the requester not granted last wins.
REQ-019 SHALL update the last-granted pointer on entry to ISSUE.
REQ-020 SHALL, in ISSUE, assert exactly one of csr_wr/csr_rd for exactly one cycle, with csr_addr and csr_wr_data taken from the latched values.
REQ-021 SHALL go from ISSUE to ACK for a write, and from ISSUE to RDWAIT for a read.
REQ-022 SHALL, in RDWAIT, capture csr_rd_data into the winner's rdata register at the cycle end, then go to ACK.
REQ-023 SHALL, in ACK, pulse the winner's ack for one cycle, then return to IDLE.
REQ-024 SHALL give these latencies with req sampled at cycle T:
  - write: csr_wr at T+1, ack at T+2;
  - read: csr_rd at T+1, capture at T+2, ack at T+3.
REQ-025 SHALL re-arbitrate in the IDLE cycle after ACK; a req still high there is a new transaction, allowing back-to-back accesses every 3 cycles (write) or 4 cycles (read).
REQ-026 SHALL hold mN_rdata until the next read ack to that same requester; writes and the other requester's accesses SHALL NOT alter it.
REQ-027 SHALL, if the winner drops req before ack, still complete the latched transaction and pulse ack.
REQ-028 SHALL keep csr_addr and csr_wr_data at their last latched values outside ISSUE, with csr_rd = csr_wr = 0.
REQ-029 SHALL never assert both acks, both strobes, or an ack and a strobe in the same cycle.
REQ-030 SHALL ignore mN_wr, mN_addr and mN_wdata while mN_req is low.

Reset
REQ-031 SHALL, on areset high, immediately and asynchronously set:
  - state IDLE;
  - csr_rd, csr_wr, m0_ack, m1_ack = 0;
  - csr_addr, csr_wr_data, m0_rdata, m1_rdata = 0;
  - last-granted pointer = m1, so m0 wins the first tie.
REQ-032 SHALL abandon any in-flight transaction on reset without issuing an ack; the first req after reset release is arbitrated from IDLE.

Verification
REQ-033 Bench SHALL drive m0 write addr 0x08, data 0xDEADBEEF at T -> csr_wr=1, csr_addr=0x08, csr_wr_data=0xDEADBEEF at T+1; m0_ack=1 at T+2; m1_ack stays 0.
REQ-034 Bench SHALL drive m1 read addr 0x04 with csr_rd_data=0x12345678 at T+2 -> csr_rd at T+1; m1_ack at T+3 with m1_rdata=0x12345678; m0_rdata unchanged.
REQ-035 Bench SHALL hold m0_req and m1_req high (reads) from reset release -> grant order m0, m1, m0, m1; one ack every 4 cycles.
REQ-036 Bench SHALL assert areset in RDWAIT -> strobes and acks 0 at once, no ack issued, both rdata = 0; next m1 read completes normally.
REQ-037 Bench SHALL drop m0_req one cycle after grant on a write -> csr_wr is still issued and m0_ack still pulses at T+2.
